// File: rtl/sra_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sra_pkg: shared definitions for the SRA magnitude-datapath sequencer.
//   - state_e        : sequencer state encoding
//   - U1_* / U2_*    : operation codes for the abs/max/min unit and the
//                      sub/add/max unit
//   - *_LSB, B_*     : bit positions of every field in the 27-bit Control word
//   - R1..R5         : register index inside the r_reg / w_reg fields
// -----------------------------------------------------------------------------
package sra_pkg;

   localparam int CTRL_W = 27;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LOAD = 4'd1,
      S_ABS1 = 4'd2,
      S_ABS2 = 4'd3,
      S_MAX  = 4'd4,
      S_MIN  = 4'd5,
      S_SUB  = 4'd6,
      S_ADD  = 4'd7,
      S_MAX2 = 4'd8,
      S_DONE = 4'd9
   } state_e;

   // Abs/max/min unit (A = R1, B = bus BU1)
   localparam logic [1:0] U1_ABS_A = 2'b00;
   localparam logic [1:0] U1_ABS_B = 2'b01;
   localparam logic [1:0] U1_MAX   = 2'b10;
   localparam logic [1:0] U1_MIN   = 2'b11;

   // Sub/add/max unit (operands from buses A and B)
   localparam logic [1:0] U2_SUB    = 2'b00;
   localparam logic [1:0] U2_ADD    = 2'b01;
   localparam logic [1:0] U2_MAX    = 2'b10;
   localparam logic [1:0] U2_PASS_A = 2'b11;

   // Field positions
   localparam int R_LSB   = 22;  // r_reg[4:0] at [26:22]
   localparam int W_LSB   = 17;  // w_reg[4:0] at [21:17]
   localparam int CU1_LSB = 15;  // c_U1 at [16:15]
   localparam int CU2_LSB = 13;  // c_U2 at [14:13]

   // Register index inside r_reg / w_reg
   localparam int R1 = 0;
   localparam int R2 = 1;
   localparam int R3 = 2;
   localparam int R4 = 3;
   localparam int R5 = 4;

   // Single-bit bus enables
   localparam int B_S1_R1  = 12;
   localparam int B_S0_R1  = 11;
   localparam int B_S1_R2  = 10;
   localparam int B_S0_R2  = 9;
   localparam int B_S1_BU1 = 8;
   localparam int B_S0_BU1 = 7;
   localparam int B_S1_R5  = 6;
   localparam int B_S0_R5  = 5;
   localparam int B_S1_A   = 4;
   localparam int B_S0_A   = 3;
   localparam int B_S1_B   = 2;
   localparam int B_S0_B   = 1;
   localparam int B_C_OUT  = 0;

endpackage

// File: rtl/sra_sequencer_if.sv
// -----------------------------------------------------------------------------
// sra_sequencer_if: host handshake plus datapath control word.
//   start   : host request, sampled on clk rising edge
//   busy    : sequencer is not idle
//   done    : one-cycle pulse, datapath OUT valid in that cycle
//   Control : 27-bit datapath control word
// Handshake: start is a level sampled every edge; it is honoured only while
// the sequencer is idle or in its final (done) cycle, otherwise ignored.
// Nothing is queued, so the host must watch done/busy itself.
// Modports: master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface sra_sequencer_if
   import sra_pkg::*;
   ();

   logic              start;
   logic              busy;
   logic              done;
   logic [CTRL_W-1:0] Control;

   modport master (output start, input busy, input done, input Control);
   modport slave  (input start, output busy, output done, output Control);

endinterface

// File: rtl/sra_sequencer_ctrl_decode.sv
// -----------------------------------------------------------------------------
// sra_ctrl_decode: purely combinational state -> Control/busy/done decoder.
//   state_i : current (registered) sequencer state
//   ctrl_o  : 27-bit datapath Control word
//   busy_o  : high in every state except S_IDLE
//   done_o  : high only in S_DONE
// Every bit not explicitly set for a state stays 0, which keeps each bus
// enable pair mutually exclusive and leaves undriven buses unwritten.
// -----------------------------------------------------------------------------
module sra_ctrl_decode
   import sra_pkg::*;
(
   input  state_e            state_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              busy_o,
   output logic              done_o
);

   always_comb begin
      ctrl_o = '0;
      busy_o = (state_i != S_IDLE);
      done_o = 1'b0;
      case (state_i)
         S_LOAD: begin   // R1 <= In0, R2 <= In1
            ctrl_o[B_S0_R1]   = 1'b1;
            ctrl_o[B_S0_R2]   = 1'b1;
            ctrl_o[W_LSB+R1]  = 1'b1;
            ctrl_o[W_LSB+R2]  = 1'b1;
         end
         S_ABS1: begin   // R1 <= |a|
            ctrl_o[CU1_LSB+:2] = U1_ABS_A;
            ctrl_o[R_LSB+R1]   = 1'b1;
            ctrl_o[B_S1_R1]    = 1'b1;
            ctrl_o[W_LSB+R1]   = 1'b1;
         end
         S_ABS2: begin   // R2 <= |b|, R2 reaches U1 through BU1
            ctrl_o[CU1_LSB+:2] = U1_ABS_B;
            ctrl_o[R_LSB+R1]   = 1'b1;
            ctrl_o[R_LSB+R2]   = 1'b1;
            ctrl_o[B_S1_BU1]   = 1'b1;
            ctrl_o[B_S1_R2]    = 1'b1;
            ctrl_o[W_LSB+R2]   = 1'b1;
         end
         S_MAX: begin    // R4 <= x, R5 <= x>>3
            ctrl_o[CU1_LSB+:2] = U1_MAX;
            ctrl_o[R_LSB+R1]   = 1'b1;
            ctrl_o[R_LSB+R2]   = 1'b1;
            ctrl_o[B_S1_BU1]   = 1'b1;
            ctrl_o[W_LSB+R4]   = 1'b1;
            ctrl_o[B_S0_R5]    = 1'b1;
            ctrl_o[W_LSB+R5]   = 1'b1;
         end
         S_MIN: begin    // R3 <= y>>1
            ctrl_o[CU1_LSB+:2] = U1_MIN;
            ctrl_o[R_LSB+R1]   = 1'b1;
            ctrl_o[R_LSB+R2]   = 1'b1;
            ctrl_o[B_S1_BU1]   = 1'b1;
            ctrl_o[W_LSB+R3]   = 1'b1;
         end
         S_SUB: begin    // R5 <= R4 - R5
            ctrl_o[CU2_LSB+:2] = U2_SUB;
            ctrl_o[R_LSB+R4]   = 1'b1;
            ctrl_o[R_LSB+R5]   = 1'b1;
            ctrl_o[B_S1_A]     = 1'b1;
            ctrl_o[B_S0_B]     = 1'b1;
            ctrl_o[B_S1_R5]    = 1'b1;
            ctrl_o[W_LSB+R5]   = 1'b1;
         end
         S_ADD: begin    // R5 <= R5 + R3
            ctrl_o[CU2_LSB+:2] = U2_ADD;
            ctrl_o[R_LSB+R5]   = 1'b1;
            ctrl_o[R_LSB+R3]   = 1'b1;
            ctrl_o[B_S0_A]     = 1'b1;
            ctrl_o[B_S1_B]     = 1'b1;
            ctrl_o[B_S1_R5]    = 1'b1;
            ctrl_o[W_LSB+R5]   = 1'b1;
         end
         S_MAX2: begin   // R5 <= max(R4, R5)
            ctrl_o[CU2_LSB+:2] = U2_MAX;
            ctrl_o[R_LSB+R4]   = 1'b1;
            ctrl_o[R_LSB+R5]   = 1'b1;
            ctrl_o[B_S1_A]     = 1'b1;
            ctrl_o[B_S0_B]     = 1'b1;
            ctrl_o[B_S1_R5]    = 1'b1;
            ctrl_o[W_LSB+R5]   = 1'b1;
         end
         S_DONE: begin   // drive R5 onto OUT
            ctrl_o[R_LSB+R5]   = 1'b1;
            ctrl_o[B_C_OUT]    = 1'b1;
            done_o             = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sra_sequencer.sv
// -----------------------------------------------------------------------------
// sra_sequencer: Moore sequencer for the SRA magnitude datapath, computing
// r = max((x - x>>3) + y>>1, x) with x = max(|a|,|b|), y = min(|a|,|b|).
//   clk     : datapath clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : slave side of sra_sequencer_if (start, busy, done, Control)
//   state_o : current state, for observation only
// Parameter EN_FINAL_MAX: 1 keeps the final max(t2,x) step, 0 skips S_MAX2.
// Outputs decode from the state register only, so start never reaches
// Control combinationally.
// -----------------------------------------------------------------------------
module sra_sequencer
   import sra_pkg::*;
#(
   parameter bit EN_FINAL_MAX = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   sra_sequencer_if.slave bus,
   output state_e        state_o
);

   state_e state_q, state_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; unused encodings fall back to S_IDLE
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = bus.start ? S_LOAD : S_IDLE;
         S_LOAD:  state_d = S_ABS1;
         S_ABS1:  state_d = S_ABS2;
         S_ABS2:  state_d = S_MAX;
         S_MAX:   state_d = S_MIN;
         S_MIN:   state_d = S_SUB;
         S_SUB:   state_d = S_ADD;
         S_ADD:   state_d = EN_FINAL_MAX ? S_MAX2 : S_DONE;
         S_MAX2:  state_d = S_DONE;
         S_DONE:  state_d = bus.start ? S_LOAD : S_IDLE;  // back-to-back restart
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   sra_ctrl_decode u_decode (
      .state_i (state_q),
      .ctrl_o  (bus.Control),
      .busy_o  (bus.busy),
      .done_o  (bus.done)
   );

   assign state_o = state_q;

endmodule
